// File: rtl/scoreboard.sv
// Register scoreboard for the issue stage: tracks in-flight writes per register and
// raises RAW/WAW stalls from per-register forwarding countdowns.
module scoreboard #(
  parameter int NREGS = 32,
  parameter int CNTW  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs,
  input  logic [4:0]       issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic             issue_wr,
  input  logic [4:0]       issue_rd,
  input  logic [CNTW-1:0]  issue_lat,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic             accept,
  output logic [NREGS-1:0] busy,
  output logic [5:0]       pending_count
);

  logic [NREGS-1:0] r_busy;
  logic [CNTW-1:0]  r_cnt [NREGS];
  logic [5:0]       r_pending;

  logic [NREGS-1:0] w_busy_nxt;
  logic [CNTW-1:0]  w_cnt_nxt [NREGS];
  logic [5:0]       w_pop;
  logic             w_raw;
  logic             w_waw;

  // Register 0 never gets set, so its counter and busy bit read as zero.
  always_comb begin
    w_raw = issue_valid &&
            ((issue_use_rs && (issue_rs != 5'd0) && (r_cnt[issue_rs] != '0)) ||
             (issue_use_rt && (issue_rt != 5'd0) && (r_cnt[issue_rt] != '0)));
    w_waw = issue_valid && issue_wr && (issue_rd != 5'd0) &&
            r_busy[issue_rd] && (r_cnt[issue_rd] > issue_lat);
    stall  = (w_raw || w_waw) && !flush;
    accept = issue_valid && !stall && !flush;
  end

  always_comb begin
    w_busy_nxt = r_busy;
    w_pop      = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_cnt_nxt[r] = (r_cnt[r] != '0) ? (r_cnt[r] - 1'b1) : '0;
      if (flush) begin
        w_busy_nxt[r] = 1'b0;
        w_cnt_nxt[r]  = '0;
      end else if (accept && issue_wr && (issue_rd == 5'(r))) begin
        w_busy_nxt[r] = 1'b1;
        w_cnt_nxt[r]  = issue_lat;
      end else if (wb_valid && (wb_rd == 5'(r))) begin
        w_busy_nxt[r] = 1'b0;
        w_cnt_nxt[r]  = '0;
      end
      if (r == 0) begin
        w_busy_nxt[r] = 1'b0;
        w_cnt_nxt[r]  = '0;
      end
      w_pop = w_pop + 6'(w_busy_nxt[r]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy    <= '0;
      r_cnt     <= '{default: '0};
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pop;
    end
  end

  assign busy          = r_busy;
  assign pending_count = r_pending;

endmodule

// File: tb/tb_scoreboard.sv
// Randomized + directed bench for scoreboard; expectations come from a
// ready-time model (absolute cycle at which each register becomes forwardable).
module tb_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs = '0, issue_rt = '0, issue_rd = '0, wb_rd = '0;
  logic        issue_use_rs = 1'b0, issue_use_rt = 1'b0, issue_wr = 1'b0;
  logic [2:0]  issue_lat = '0;
  logic        wb_valid = 1'b0, flush = 1'b0;
  logic        stall, accept;
  logic [31:0] busy;
  logic [5:0]  pending_count;

  scoreboard #(.NREGS(32), .CNTW(3)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .accept(accept), .busy(busy), .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic v; logic [4:0] rs; logic urs; logic [4:0] rt; logic urt;
    logic wr; logic [4:0] rd; logic [2:0] lat;
    logic wbv; logic [4:0] wbrd; logic fl; logic rl;
  } stim_t;

  typedef struct packed {
    logic stall; logic accept; logic [31:0] busy; logic [5:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ready_at [32];
  bit   busy_m   [32];

  function automatic int cnt_m(input int r);
    return (r != 0 && ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) begin
      ready_at[r] = 0;
      busy_m[r]   = 1'b0;
    end
  endtask

  task automatic step(input stim_t s, output bit acc);
    exp_t e;
    bit raw, waw, stl;
    int pend;
    reset = !s.rl;
    issue_valid = s.v; issue_rs = s.rs; issue_rt = s.rt;
    issue_use_rs = s.urs; issue_use_rt = s.urt; issue_wr = s.wr;
    issue_rd = s.rd; issue_lat = s.lat; wb_valid = s.wbv; wb_rd = s.wbrd; flush = s.fl;
    if (s.rl) clear_model();
    raw = s.v && ((s.urs && cnt_m(int'(s.rs)) > 0) || (s.urt && cnt_m(int'(s.rt)) > 0));
    waw = s.v && s.wr && s.rd != 0 && busy_m[s.rd] && cnt_m(int'(s.rd)) > int'(s.lat);
    stl = (raw || waw) && !s.fl;
    acc = s.v && !stl && !s.fl;
    pend = 0;
    e.busy = '0;
    for (int r = 0; r < 32; r++) begin
      e.busy[r] = busy_m[r];
      pend += int'(busy_m[r]);
    end
    e.stall = stl; e.accept = acc; e.pend = 6'(pend);
    exp_q.push_back(e);
    if (!s.rl) begin
      if (s.fl) clear_model();
      else begin
        if (s.wbv && s.wbrd != 0) begin
          busy_m[s.wbrd] = 1'b0;
          ready_at[s.wbrd] = 0;
        end
        if (acc && s.wr && s.rd != 0) begin
          busy_m[s.rd] = 1'b1;
          ready_at[s.rd] = cyc + 1 + int'(s.lat);
        end
      end
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  // Present an instruction and hold it until it is accepted (bounded).
  task automatic issue_hold(input stim_t s, input int max_cyc);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < max_cyc && !acc; i++) step(s, acc);
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL hold_accept: instruction not accepted within %0d cycles (rd=%0d rs=%0d)",
               max_cyc, s.rd, s.rs);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests += 4;
        if (stall !== e.stall) begin
          n_fail++;
          $display("FAIL stall @%0t: got %0b want %0b", $time, stall, e.stall);
        end
        if (accept !== e.accept) begin
          n_fail++;
          $display("FAIL accept @%0t: got %0b want %0b", $time, accept, e.accept);
        end
        if (busy !== e.busy) begin
          n_fail++;
          $display("FAIL busy @%0t: got %h want %h", $time, busy, e.busy);
        end
        if (pending_count !== e.pend) begin
          n_fail++;
          $display("FAIL pending_count @%0t: got %0d want %0d", $time, pending_count, e.pend);
        end
      end
    end
  end

  initial begin : stim
    stim_t s, cur;
    bit acc, have;
    clear_model();
    @(posedge clock); #1;
    s = idle(); s.rl = 1'b1;
    step(s, acc);
    s.v = 1'b1; s.urs = 1'b1; s.rs = 5'd3; s.wr = 1'b1; s.rd = 5'd3;
    step(s, acc);

    // load-use
    s = idle(); s.v = 1; s.wr = 1; s.rd = 5; s.lat = 1; step(s, acc);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 5; s.wr = 1; s.rd = 6; issue_hold(s, 5);
    // ALU chain, then write-back of r3
    s = idle(); s.v = 1; s.wr = 1; s.rd = 3; s.lat = 0; step(s, acc);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 3; s.wr = 1; s.rd = 10; issue_hold(s, 2);
    s = idle(); step(s, acc);
    s = idle(); s.wbv = 1; s.wbrd = 3; step(s, acc);
    // WAW behind a 4-cycle multiply
    s = idle(); s.v = 1; s.wr = 1; s.rd = 8; s.lat = 4; step(s, acc);
    s = idle(); s.v = 1; s.wr = 1; s.rd = 8; s.lat = 0; issue_hold(s, 8);
    // zero register
    s = idle(); s.v = 1; s.wr = 1; s.rd = 0; s.lat = 1; step(s, acc);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 0; s.urt = 1; s.rt = 0; issue_hold(s, 1);
    // flush with busy {2,7,9}
    s = idle(); s.v = 1; s.wr = 1; s.rd = 2; s.lat = 3; step(s, acc);
    s.rd = 7; s.lat = 5; step(s, acc);
    s.rd = 9; s.lat = 7; step(s, acc);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 4; s.wr = 1; s.rd = 12; s.fl = 1; step(s, acc);
    s = idle(); s.v = 1; s.urs = 1; s.rs = 9; step(s, acc);
    // same-cycle write-back and issue to r4
    s = idle(); s.v = 1; s.wr = 1; s.rd = 4; s.lat = 3; step(s, acc);
    s = idle(); s.v = 1; s.wr = 1; s.rd = 4; s.lat = 2; s.wbv = 1; s.wbrd = 4; step(s, acc);
    s = idle(); s.v = 1; s.urt = 1; s.rt = 4; issue_hold(s, 5);

    // randomized traffic with a mid-run reset
    have = 1'b0;
    cur = idle();
    for (int i = 0; i < 700; i++) begin
      if (!have || $urandom_range(0, 9) < 3) begin
        cur = idle();
        cur.v   = ($urandom_range(0, 9) < 8);
        cur.rs  = 5'($urandom_range(0, 7));
        cur.rt  = 5'($urandom_range(0, 7));
        cur.urs = $urandom_range(0, 1);
        cur.urt = $urandom_range(0, 1);
        cur.wr  = ($urandom_range(0, 9) < 7);
        cur.rd  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
        cur.lat = 3'($urandom_range(0, 7));
      end
      s = cur;
      s.wbv  = ($urandom_range(0, 3) == 0);
      s.wbrd = 5'($urandom_range(0, 7));
      s.fl   = ($urandom_range(0, 29) == 0);
      s.rl   = (i == 350 || i == 351);
      step(s, acc);
      have = !acc;
    end

    s = idle();
    step(s, acc);
    repeat (2) @(negedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected items left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
